// File: rtl/decode_stage.sv
// decode_stage: registered RV32 decode pipeline stage.
// Fetch hands over raw instruction words with a valid/ready handshake.
// Each word is decoded combinationally, then captured into a head entry
// and, when BUFFER_DEPTH is 2, a skid entry. Execute drains the head
// through its own valid/ready handshake. A flush drops every buffered
// and incoming word. The decoded_count output counts bundles consumed
// downstream and saturates at its maximum value.
module decode_stage #(
  parameter int COUNTER_WIDTH = 16,
  parameter int BUFFER_DEPTH  = 2,
  parameter bit ENABLE_M      = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instruction,
  input  logic [31:0]              in_pc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_immediate,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [4:0]               out_rd,
  output logic                     out_reg_we,
  output logic [2:0]               out_alu_op,
  output logic                     out_alu_sub,
  output logic                     out_alu_signed,
  output logic                     out_use_immediate,
  output logic                     out_is_mul,
  output logic                     out_load_memory,
  output logic                     out_store_memory,
  output logic [1:0]               out_memory_mask,
  output logic                     out_memory_sign_extension,
  output logic                     out_conditional_jump,
  output logic                     out_unconditional_jump,
  output logic                     out_load_pc,
  output logic                     out_store_pc,
  output logic                     out_load_immediate,
  output logic                     out_ebreak,
  output logic                     out_illegal,
  output logic [COUNTER_WIDTH-1:0] decoded_count
);

  // Major opcode groups, keyed on instruction bits [6:2].
  // The two RV64 word groups are accepted as legal no-ops.
  typedef enum logic [4:0] {
    OpLoad    = 5'b00000,
    OpMiscMem = 5'b00011,
    OpImm     = 5'b00100,
    OpAuipc   = 5'b00101,
    OpImm32   = 5'b00110,
    OpStore   = 5'b01000,
    OpReg     = 5'b01100,
    OpLui     = 5'b01101,
    OpReg32   = 5'b01110,
    OpBranch  = 5'b11000,
    OpJalr    = 5'b11001,
    OpJal     = 5'b11011,
    OpSystem  = 5'b11100
  } OpClass;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] immediate;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        regWe;
    logic [2:0]  aluOp;
    logic        aluSub;
    logic        aluSigned;
    logic        useImmediate;
    logic        isMul;
    logic        loadMemory;
    logic        storeMemory;
    logic [1:0]  memoryMask;
    logic        memorySignExtension;
    logic        conditionalJump;
    logic        unconditionalJump;
    logic        loadPc;
    logic        storePc;
    logic        loadImmediate;
    logic        ebreak;
    logic        illegal;
  } DecodedBundle;

  localparam bit UseSkid = (BUFFER_DEPTH == 2);

  OpClass       opClass;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  logic [31:0]  immI;
  logic [31:0]  immS;
  logic [31:0]  immB;
  logic [31:0]  immU;
  logic [31:0]  immJ;
  logic         legalGroup;
  logic         regIllegal;
  logic         branchIllegal;
  DecodedBundle decoded;

  DecodedBundle head_q;
  DecodedBundle head_d;
  DecodedBundle skid_q;
  DecodedBundle skid_d;
  logic         headValid_q;
  logic         headValid_d;
  logic         skidValid_q;
  logic         skidValid_d;
  logic [COUNTER_WIDTH-1:0] count_q;
  logic [COUNTER_WIDTH-1:0] count_d;

  logic readyBase;
  logic inFire;
  logic outFire;

  assign opClass = OpClass'(in_instruction[6:2]);
  assign funct3  = in_instruction[14:12];
  assign funct7  = in_instruction[31:25];

  assign immI = {{20{in_instruction[31]}}, in_instruction[31:20]};
  assign immS = {{20{in_instruction[31]}}, in_instruction[31:25], in_instruction[11:7]};
  assign immB = {{19{in_instruction[31]}}, in_instruction[31], in_instruction[7],
                 in_instruction[30:25], in_instruction[11:8], 1'b0};
  assign immU = {in_instruction[31:12], 12'b0};
  assign immJ = {{11{in_instruction[31]}}, in_instruction[31], in_instruction[19:12],
                 in_instruction[20], in_instruction[30:21], 1'b0};

  // Decode the incoming word into a bundle; illegal words keep flowing
  // but lose every architectural side effect.
  always_comb begin
    decoded       = '0;
    legalGroup    = 1'b1;
    regIllegal    = 1'b0;
    branchIllegal = 1'b0;
    decoded.pc    = in_pc;
    decoded.rs1   = in_instruction[19:15];
    decoded.rs2   = in_instruction[24:20];
    decoded.rd    = in_instruction[11:7];
    case (opClass)
      OpLoad: begin
        decoded.immediate           = immI;
        decoded.regWe               = 1'b1;
        decoded.useImmediate        = 1'b1;
        decoded.loadMemory          = 1'b1;
        decoded.memoryMask          = funct3[1:0];
        decoded.memorySignExtension = ~funct3[2];
      end
      OpMiscMem: begin
        decoded.immediate = immI;
      end
      OpImm: begin
        decoded.immediate    = immI;
        decoded.regWe        = 1'b1;
        decoded.useImmediate = 1'b1;
        decoded.aluOp        = funct3;
        decoded.aluSigned    = (funct3 == 3'b101) & funct7[5];
      end
      OpAuipc: begin
        decoded.immediate    = immU;
        decoded.regWe        = 1'b1;
        decoded.useImmediate = 1'b1;
        decoded.loadPc       = 1'b1;
      end
      OpStore: begin
        decoded.immediate    = immS;
        decoded.useImmediate = 1'b1;
        decoded.storeMemory  = 1'b1;
        decoded.memoryMask   = funct3[1:0];
      end
      OpReg: begin
        decoded.regWe     = 1'b1;
        decoded.aluOp     = funct3;
        decoded.aluSub    = (funct3 == 3'b000) & funct7[5];
        decoded.aluSigned = funct7[5];
        decoded.isMul     = (funct7 == 7'b0000001);
        if (funct7 == 7'b0000001) begin
          regIllegal = ~ENABLE_M;
        end else if (funct7 == 7'b0100000) begin
          regIllegal = (funct3 != 3'b000) && (funct3 != 3'b101);
        end else begin
          regIllegal = (funct7 != 7'b0000000);
        end
      end
      OpLui: begin
        decoded.immediate     = immU;
        decoded.regWe         = 1'b1;
        decoded.useImmediate  = 1'b1;
        decoded.loadImmediate = 1'b1;
        decoded.rs1           = 5'd0;
      end
      OpBranch: begin
        decoded.immediate       = immB;
        decoded.conditionalJump = 1'b1;
        decoded.aluOp           = funct3;
        branchIllegal           = (funct3[2:1] == 2'b01);
      end
      OpJalr: begin
        decoded.immediate         = immI;
        decoded.regWe             = 1'b1;
        decoded.useImmediate      = 1'b1;
        decoded.unconditionalJump = 1'b1;
        decoded.storePc           = 1'b1;
      end
      OpJal: begin
        decoded.immediate         = immJ;
        decoded.regWe             = 1'b1;
        decoded.useImmediate      = 1'b1;
        decoded.unconditionalJump = 1'b1;
        decoded.storePc           = 1'b1;
      end
      OpSystem: begin
        decoded.immediate = immI;
        decoded.ebreak    = (funct3 == 3'b000) && (in_instruction[31:20] == 12'd1);
      end
      OpImm32, OpReg32: begin
        legalGroup = 1'b1;
      end
      default: begin
        legalGroup = 1'b0;
      end
    endcase
    decoded.illegal = (in_instruction[1:0] != 2'b11) | ~legalGroup | regIllegal | branchIllegal;
    if (decoded.illegal) begin
      decoded.regWe             = 1'b0;
      decoded.loadMemory        = 1'b0;
      decoded.storeMemory       = 1'b0;
      decoded.conditionalJump   = 1'b0;
      decoded.unconditionalJump = 1'b0;
      decoded.isMul             = 1'b0;
      decoded.ebreak            = 1'b0;
    end
  end

  // Ready to fetch: with a skid entry it depends only on buffer state,
  // with a single entry it may look through to out_ready.
  always_comb begin
    readyBase = UseSkid ? ~skidValid_q : (~headValid_q | out_ready);
    in_ready  = readyBase & ~flush & ~rst;
    inFire    = in_valid & in_ready;
    outFire   = headValid_q & out_ready & ~flush;
  end

  // Buffer and counter next state: flush empties everything, otherwise
  // the skid refills the head first and new words fill the first free slot.
  always_comb begin
    head_d      = head_q;
    skid_d      = skid_q;
    headValid_d = headValid_q;
    skidValid_d = skidValid_q;
    count_d     = count_q;
    if (flush) begin
      head_d      = '0;
      skid_d      = '0;
      headValid_d = 1'b0;
      skidValid_d = 1'b0;
    end else begin
      if (outFire) begin
        if (skidValid_q) begin
          head_d      = skid_q;
          skidValid_d = 1'b0;
        end else begin
          headValid_d = inFire;
          if (inFire) begin
            head_d = decoded;
          end
        end
      end else if (inFire) begin
        if (headValid_q) begin
          skid_d      = decoded;
          skidValid_d = 1'b1;
        end else begin
          head_d      = decoded;
          headValid_d = 1'b1;
        end
      end
      if (outFire && (count_q != '1)) begin
        count_d = count_q + COUNTER_WIDTH'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      skid_q      <= '0;
      headValid_q <= 1'b0;
      skidValid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      head_q      <= head_d;
      skid_q      <= skid_d;
      headValid_q <= headValid_d;
      skidValid_q <= skidValid_d;
      count_q     <= count_d;
    end
  end

  assign out_valid                 = headValid_q;
  assign out_pc                    = head_q.pc;
  assign out_immediate             = head_q.immediate;
  assign out_rs1                   = head_q.rs1;
  assign out_rs2                   = head_q.rs2;
  assign out_rd                    = head_q.rd;
  assign out_reg_we                = head_q.regWe;
  assign out_alu_op                = head_q.aluOp;
  assign out_alu_sub               = head_q.aluSub;
  assign out_alu_signed            = head_q.aluSigned;
  assign out_use_immediate         = head_q.useImmediate;
  assign out_is_mul                = head_q.isMul;
  assign out_load_memory           = head_q.loadMemory;
  assign out_store_memory          = head_q.storeMemory;
  assign out_memory_mask           = head_q.memoryMask;
  assign out_memory_sign_extension = head_q.memorySignExtension;
  assign out_conditional_jump      = head_q.conditionalJump;
  assign out_unconditional_jump    = head_q.unconditionalJump;
  assign out_load_pc               = head_q.loadPc;
  assign out_store_pc              = head_q.storePc;
  assign out_load_immediate        = head_q.loadImmediate;
  assign out_ebreak                = head_q.ebreak;
  assign out_illegal               = head_q.illegal;
  assign decoded_count             = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: drives two decode_stage instances from one stimulus
// stream. dutA uses a 2-entry skid buffer with RV32M and a 16-bit
// counter; dutB uses a single entry, no RV32M and a 2-bit counter.
// Both are compared every cycle against a queue-based reference model.
module tb_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush;
  logic        inValid;
  logic        outReady;
  logic [31:0] inInstruction;
  logic [31:0] inPc;

  logic inReadyA, outValidA, outRegWeA, outAluSubA, outAluSignedA, outUseImmA, outIsMulA;
  logic outLoadA, outStoreA, outSignExtA, outCondJumpA, outUncondJumpA, outLoadPcA;
  logic outStorePcA, outLoadImmA, outEbreakA, outIllegalA;
  logic [31:0] outPcA, outImmA;
  logic [4:0]  outRs1A, outRs2A, outRdA;
  logic [2:0]  outAluOpA;
  logic [1:0]  outMaskA;
  logic [15:0] countA;

  logic inReadyB, outValidB, outRegWeB, outAluSubB, outAluSignedB, outUseImmB, outIsMulB;
  logic outLoadB, outStoreB, outSignExtB, outCondJumpB, outUncondJumpB, outLoadPcB;
  logic outStorePcB, outLoadImmB, outEbreakB, outIllegalB;
  logic [31:0] outPcB, outImmB;
  logic [4:0]  outRs1B, outRs2B, outRdB;
  logic [2:0]  outAluOpB;
  logic [1:0]  outMaskB;
  logic [1:0]  countB;

  decode_stage #(.BUFFER_DEPTH(2), .ENABLE_M(1'b1), .COUNTER_WIDTH(16)) dutA (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyA),
    .in_instruction(inInstruction), .in_pc(inPc), .flush(flush),
    .out_valid(outValidA), .out_ready(outReady), .out_pc(outPcA),
    .out_immediate(outImmA), .out_rs1(outRs1A), .out_rs2(outRs2A), .out_rd(outRdA),
    .out_reg_we(outRegWeA), .out_alu_op(outAluOpA), .out_alu_sub(outAluSubA),
    .out_alu_signed(outAluSignedA), .out_use_immediate(outUseImmA), .out_is_mul(outIsMulA),
    .out_load_memory(outLoadA), .out_store_memory(outStoreA), .out_memory_mask(outMaskA),
    .out_memory_sign_extension(outSignExtA), .out_conditional_jump(outCondJumpA),
    .out_unconditional_jump(outUncondJumpA), .out_load_pc(outLoadPcA),
    .out_store_pc(outStorePcA), .out_load_immediate(outLoadImmA),
    .out_ebreak(outEbreakA), .out_illegal(outIllegalA), .decoded_count(countA)
  );

  decode_stage #(.BUFFER_DEPTH(1), .ENABLE_M(1'b0), .COUNTER_WIDTH(2)) dutB (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReadyB),
    .in_instruction(inInstruction), .in_pc(inPc), .flush(flush),
    .out_valid(outValidB), .out_ready(outReady), .out_pc(outPcB),
    .out_immediate(outImmB), .out_rs1(outRs1B), .out_rs2(outRs2B), .out_rd(outRdB),
    .out_reg_we(outRegWeB), .out_alu_op(outAluOpB), .out_alu_sub(outAluSubB),
    .out_alu_signed(outAluSignedB), .out_use_immediate(outUseImmB), .out_is_mul(outIsMulB),
    .out_load_memory(outLoadB), .out_store_memory(outStoreB), .out_memory_mask(outMaskB),
    .out_memory_sign_extension(outSignExtB), .out_conditional_jump(outCondJumpB),
    .out_unconditional_jump(outUncondJumpB), .out_load_pc(outLoadPcB),
    .out_store_pc(outStorePcB), .out_load_immediate(outLoadImmB),
    .out_ebreak(outEbreakB), .out_illegal(outIllegalB), .decoded_count(countB)
  );

  logic [98:0] obsBundle [2];
  logic        obsInReady [2];
  logic        obsOutValid [2];
  logic [15:0] obsCount [2];

  assign obsBundle[0] = {outPcA, outImmA, outRs1A, outRs2A, outRdA, outRegWeA, outAluOpA,
                         outAluSubA, outAluSignedA, outUseImmA, outIsMulA, outLoadA, outStoreA,
                         outMaskA, outSignExtA, outCondJumpA, outUncondJumpA, outLoadPcA,
                         outStorePcA, outLoadImmA, outEbreakA, outIllegalA};
  assign obsBundle[1] = {outPcB, outImmB, outRs1B, outRs2B, outRdB, outRegWeB, outAluOpB,
                         outAluSubB, outAluSignedB, outUseImmB, outIsMulB, outLoadB, outStoreB,
                         outMaskB, outSignExtB, outCondJumpB, outUncondJumpB, outLoadPcB,
                         outStorePcB, outLoadImmB, outEbreakB, outIllegalB};
  assign obsInReady[0]  = inReadyA;
  assign obsInReady[1]  = inReadyB;
  assign obsOutValid[0] = outValidA;
  assign obsOutValid[1] = outValidB;
  assign obsCount[0]    = countA;
  assign obsCount[1]    = {14'd0, countB};

  int checks   = 0;
  int failures = 0;

  // Reference model state, one set per DUT.
  logic [98:0] modelQ0 [$];
  logic [98:0] modelQ1 [$];
  int          modelCount [2];
  bit          modelIdleZero [2];
  bit          modelKnown = 1'b0;
  int          depthOf [2]   = '{2, 1};
  bit          enableMOf [2] = '{1'b1, 1'b0};
  int          countMaxOf [2] = '{65535, 3};

  logic [6:0] opList [13] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
                              7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};
  logic [6:0] f7List [3]  = '{7'h00, 7'h20, 7'h01};

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // RV32 decode rules written as per-field formulas over instruction groups.
  function automatic logic [98:0] refDecode(input logic [31:0] w, input logic [31:0] p,
                                            input bit enM);
    logic [4:0] g;
    logic [2:0] f3;
    logic [6:0] f7;
    bit isLoad, isFence, isOpImm, isAuipc, isOpImm32, isStore, isOp, isLui, isOp32;
    bit isBr, isJalr, isJal, isSys, known, f7ok, ill;
    logic [31:0] imm;
    g = w[6:2]; f3 = w[14:12]; f7 = w[31:25];
    isLoad = (g == 5'd0);   isFence = (g == 5'd3);   isOpImm = (g == 5'd4);
    isAuipc = (g == 5'd5);  isOpImm32 = (g == 5'd6); isStore = (g == 5'd8);
    isOp = (g == 5'd12);    isLui = (g == 5'd13);    isOp32 = (g == 5'd14);
    isBr = (g == 5'd24);    isJalr = (g == 5'd25);   isJal = (g == 5'd27);
    isSys = (g == 5'd28);
    known = isLoad | isFence | isOpImm | isAuipc | isOpImm32 | isStore | isOp | isLui |
            isOp32 | isBr | isJalr | isJal | isSys;
    f7ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
           (f7 == 7'h01 && enM);
    ill = (w[1:0] != 2'b11) || !known || (isOp && !f7ok) || (isBr && (f3 == 3'd2 || f3 == 3'd3));
    if (isLoad || isFence || isOpImm || isJalr || isSys) imm = 32'($signed(w[31:20]));
    else if (isStore) imm = 32'($signed({w[31:25], w[11:7]}));
    else if (isBr) imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
    else if (isAuipc || isLui) imm = {w[31:12], 12'd0};
    else if (isJal) imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
    else imm = 32'd0;
    return {p, imm, (isLui ? 5'd0 : w[19:15]), w[24:20], w[11:7],
            !ill && (isLoad || isOpImm || isAuipc || isOp || isLui || isJalr || isJal),
            ((isOpImm || isOp || isBr) ? f3 : 3'd0),
            isOp && f3 == 3'd0 && f7[5],
            (isOp || (isOpImm && f3 == 3'd5)) && f7[5],
            isLoad || isOpImm || isAuipc || isStore || isLui || isJalr || isJal,
            !ill && isOp && f7 == 7'h01,
            !ill && isLoad, !ill && isStore,
            ((isLoad || isStore) ? f3[1:0] : 2'd0),
            isLoad && !f3[2],
            !ill && isBr, !ill && (isJal || isJalr),
            isAuipc, isJal || isJalr, isLui,
            !ill && isSys && f3 == 3'd0 && w[31:20] == 12'd1,
            ill};
  endfunction

  function automatic logic [31:0] genInstr();
    logic [31:0] w;
    int k;
    k = $urandom_range(0, 9);
    w = $urandom;
    if (k < 6) begin
      w[6:0] = opList[$urandom_range(0, 12)];
      if (w[6:0] == 7'h33 && $urandom_range(0, 3) != 0) w[31:25] = f7List[$urandom_range(0, 2)];
    end else if (k == 6) begin
      w = 32'h00100073;
    end
    return w;
  endfunction

  task automatic applyStimulus(input bit r, input bit f, input bit v, input bit o,
                               input logic [31:0] ins, input logic [31:0] p);
    rst = r; flush = f; inValid = v; outReady = o; inInstruction = ins; inPc = p;
  endtask

  // Compare one DUT against the model, then advance the model past the edge.
  task automatic modelCycle(input int d);
    int size;
    bit expReady;
    logic [98:0] front;
    size = (d == 0) ? modelQ0.size() : modelQ1.size();
    front = '0;
    if (size > 0) front = (d == 0) ? modelQ0[0] : modelQ1[0];
    expReady = !rst && !flush && ((depthOf[d] == 2) ? (size < 2) : (size == 0 || outReady));
    if (modelKnown) begin
      checkOutput($sformatf("in_ready[%0d]", d), 128'(obsInReady[d]), 128'(expReady));
      checkOutput($sformatf("out_valid[%0d]", d), 128'(obsOutValid[d]), 128'(size > 0));
      if (size > 0) checkOutput($sformatf("bundle[%0d]", d), 128'(obsBundle[d]), 128'(front));
      else if (modelIdleZero[d]) checkOutput($sformatf("idle_bundle[%0d]", d), 128'(obsBundle[d]), 128'd0);
      checkOutput($sformatf("decoded_count[%0d]", d), 128'(obsCount[d]), 128'(modelCount[d]));
    end
    if (rst) begin
      if (d == 0) modelQ0.delete(); else modelQ1.delete();
      modelCount[d] = 0;
      modelIdleZero[d] = 1'b1;
    end else if (flush) begin
      if (d == 0) modelQ0.delete(); else modelQ1.delete();
      modelIdleZero[d] = 1'b1;
    end else begin
      if (size > 0 && outReady) begin
        if (d == 0) void'(modelQ0.pop_front()); else void'(modelQ1.pop_front());
        if (modelCount[d] < countMaxOf[d]) modelCount[d]++;
        modelIdleZero[d] = 1'b0;
      end
      if (inValid && expReady) begin
        if (d == 0) modelQ0.push_back(refDecode(inInstruction, inPc, enableMOf[d]));
        else modelQ1.push_back(refDecode(inInstruction, inPc, enableMOf[d]));
        modelIdleZero[d] = 1'b0;
      end
    end
  endtask

  task automatic runCycle(input bit r, input bit f, input bit v, input bit o,
                          input logic [31:0] ins, input logic [31:0] p, input int row);
    @(negedge clk);
    applyStimulus(r, f, v, o, ins, p);
    #1;
    if (row == 3) begin
      checkOutput("addi_imm", 128'(outImmA), 128'(32'hFFFFFFFF));
      checkOutput("addi_rd_rs1", 128'({outRdA, outRs1A}), 128'({5'd1, 5'd2}));
      checkOutput("addi_pc", 128'(outPcA), 128'(32'h100));
    end else if (row == 4) begin
      checkOutput("mul_is_mul_A", 128'(outIsMulA), 128'd1);
      checkOutput("mul_illegal_B", 128'({outIllegalB, outRegWeB}), 128'(2'b10));
    end else if (row == 6) begin
      checkOutput("ebreak_A", 128'({outEbreakA, outIllegalA}), 128'(2'b10));
    end else if (row == 16) begin
      checkOutput("flush_in_ready_A", 128'(inReadyA), 128'd0);
    end
    modelCycle(0);
    modelCycle(1);
    modelKnown = 1'b1;
  endtask

  typedef struct {
    bit r, f, v, o;
    logic [31:0] ins;
    logic [31:0] p;
  } Row;

  initial begin
    Row dirRows [18];
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    dirRows[0]  = '{1, 0, 0, 1, 32'h0, 32'h0};
    dirRows[1]  = '{1, 0, 0, 1, 32'h0, 32'h0};
    dirRows[2]  = '{0, 0, 1, 1, 32'hFFF10093, 32'h100};
    dirRows[3]  = '{0, 0, 1, 1, 32'h022081B3, 32'h104};
    dirRows[4]  = '{0, 0, 1, 1, 32'h00000000, 32'h108};
    dirRows[5]  = '{0, 0, 1, 1, 32'h00100073, 32'h10C};
    dirRows[6]  = '{0, 0, 0, 1, 32'h0, 32'h0};
    dirRows[7]  = '{0, 0, 1, 0, 32'h00500293, 32'h200};
    dirRows[8]  = '{0, 0, 1, 0, 32'h00128333, 32'h204};
    dirRows[9]  = '{0, 0, 1, 0, 32'h123453B7, 32'h208};
    dirRows[10] = '{0, 0, 1, 0, 32'h123453B7, 32'h208};
    dirRows[11] = '{0, 0, 1, 1, 32'h123453B7, 32'h208};
    dirRows[12] = '{0, 0, 1, 1, 32'h123453B7, 32'h208};
    dirRows[13] = '{0, 0, 0, 1, 32'h0, 32'h0};
    dirRows[14] = '{0, 0, 1, 0, 32'h00112423, 32'h300};
    dirRows[15] = '{0, 0, 1, 0, 32'h00208863, 32'h304};
    dirRows[16] = '{0, 1, 1, 1, 32'h008000EF, 32'h308};
    dirRows[17] = '{0, 0, 0, 1, 32'h0, 32'h0};
    for (int i = 0; i < 18; i++) begin
      runCycle(dirRows[i].r, dirRows[i].f, dirRows[i].v, dirRows[i].o,
               dirRows[i].ins, dirRows[i].p, i);
    end
    for (int i = 0; i < 3000; i++) begin
      runCycle($urandom_range(0, 399) == 0, $urandom_range(0, 29) == 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
               genInstr(), $urandom & 32'hFFFF_FFFC, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
